// File: rtl/plic_target.sv
// rtl/plic_target.sv - per-hart PLIC target: priority arbitration, eip generation, claim/complete handshake
module plic_target #(
    parameter int NSRC = 8,
    parameter int IDW  = 4,
    parameter int PW   = 5
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NSRC-1:0]      ip,
    input  logic [NSRC*PW-1:0]   prio,
    input  logic [PW-1:0]        thres,
    input  logic                 claim_rd,
    output logic [IDW-1:0]       claim_data,
    input  logic                 complete_wr,
    input  logic [IDW-1:0]       complete_id,
    output logic [NSRC-1:0]      ack,
    output logic                 eip,
    output logic [NSRC-1:0]      in_service
);

    logic [IDW-1:0] best_id;
    logic [PW-1:0]  best_prio;
    logic [IDW-1:0] next_id;
    logic [PW-1:0]  next_prio;
    logic           claim_hit;

    // Strict '>' against the running max keeps the lowest ID on ties; a
    // running max starting at 0 also rejects priority-0 sources.
    always_comb begin
        next_id   = '0;
        next_prio = '0;
        for (int i = 0; i < NSRC; i++) begin
            if (ip[i] && !in_service[i] &&
                (prio[i*PW +: PW] > thres) &&
                (prio[i*PW +: PW] > next_prio)) begin
                next_id   = IDW'(i + 1);
                next_prio = prio[i*PW +: PW];
            end
        end
    end

    // A registered winner always carries a nonzero priority.
    assign claim_hit = claim_rd && (best_prio != '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            claim_data <= '0;
            ack        <= '0;
            eip        <= 1'b0;
            in_service <= '0;
            best_id    <= '0;
            best_prio  <= '0;
        end else begin
            ack <= '0;
            if (claim_rd) begin
                claim_data <= best_id;
                best_id    <= '0;
                best_prio  <= '0;
                eip        <= 1'b0;
            end else begin
                best_id    <= next_id;
                best_prio  <= next_prio;
                eip        <= (next_id != '0);
            end
            for (int i = 0; i < NSRC; i++) begin
                if (claim_hit && (best_id == IDW'(i + 1))) begin
                    in_service[i] <= 1'b1;
                    ack[i]        <= 1'b1;
                end else if (complete_wr && (complete_id == IDW'(i + 1))) begin
                    in_service[i] <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_plic_target.sv
// tb/tb_plic_target.sv - directed self-checking bench for plic_target
module tb_plic_target;

    localparam int NSRC = 8;
    localparam int IDW  = 4;
    localparam int PW   = 5;

    logic                clk = 1'b0;
    logic                rst;
    logic [NSRC-1:0]     ip;
    logic [NSRC*PW-1:0]  prio;
    logic [PW-1:0]       thres;
    logic                claim_rd;
    logic [IDW-1:0]      claim_data;
    logic                complete_wr;
    logic [IDW-1:0]      complete_id;
    logic [NSRC-1:0]     ack;
    logic                eip;
    logic [NSRC-1:0]     in_service;

    int n_checks = 0;
    int n_fail   = 0;

    plic_target #(.NSRC(NSRC), .IDW(IDW), .PW(PW)) dut (
        .clk(clk), .rst(rst), .ip(ip), .prio(prio), .thres(thres),
        .claim_rd(claim_rd), .claim_data(claim_data),
        .complete_wr(complete_wr), .complete_id(complete_id),
        .ack(ack), .eip(eip), .in_service(in_service)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        ip = '0; prio = '0; thres = '0;
        claim_rd = 1'b0; complete_wr = 1'b0; complete_id = '0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic set_prio(input int idx, input logic [PW-1:0] v);
        prio[idx*PW +: PW] = v;
    endtask

    task automatic test_reset();
        rst = 1'b1; ip = 8'hFF; prio = {NSRC{5'd1}}; thres = '0;
        claim_rd = 1'b0; complete_wr = 1'b0; complete_id = '0;
        tick(); tick();
        n_checks++; if (eip !== 1'b0) begin n_fail++; $display("FAIL reset_eip: got %0b want 0", eip); end
        n_checks++; if (claim_data !== 4'd0) begin n_fail++; $display("FAIL reset_claim_data: got %0d want 0", claim_data); end
        n_checks++; if (ack !== 8'h00) begin n_fail++; $display("FAIL reset_ack: got %h want 00", ack); end
        n_checks++; if (in_service !== 8'h00) begin n_fail++; $display("FAIL reset_in_service: got %h want 00", in_service); end
        rst = 1'b0;
        tick();
        n_checks++; if (eip !== 1'b1) begin n_fail++; $display("FAIL reset_release_eip: got %0b want 1", eip); end
    endtask

    task automatic test_single();
        do_reset();
        set_prio(2, 5'd3); thres = 5'd1; ip = 8'h04;
        tick();
        n_checks++; if (eip !== 1'b1) begin n_fail++; $display("FAIL single_eip: got %0b want 1", eip); end
        claim_rd = 1'b1;
        tick();
        claim_rd = 1'b0;
        n_checks++; if (claim_data !== 4'd3) begin n_fail++; $display("FAIL single_claim: got %0d want 3", claim_data); end
        n_checks++; if (ack !== 8'h04) begin n_fail++; $display("FAIL single_ack: got %h want 04", ack); end
        n_checks++; if (in_service !== 8'h04) begin n_fail++; $display("FAIL single_in_service: got %h want 04", in_service); end
        n_checks++; if (eip !== 1'b0) begin n_fail++; $display("FAIL single_claim_eip: got %0b want 0", eip); end
        tick();
        n_checks++; if (ack !== 8'h00) begin n_fail++; $display("FAIL single_ack_pulse: got %h want 00", ack); end
        n_checks++; if (eip !== 1'b0) begin n_fail++; $display("FAIL single_masked_eip: got %0b want 0", eip); end
        n_checks++; if (claim_data !== 4'd3) begin n_fail++; $display("FAIL single_claim_hold: got %0d want 3", claim_data); end
        complete_wr = 1'b1; complete_id = 4'd3;
        tick();
        complete_wr = 1'b0;
        n_checks++; if (in_service !== 8'h00) begin n_fail++; $display("FAIL single_complete: got %h want 00", in_service); end
        tick();
        n_checks++; if (eip !== 1'b1) begin n_fail++; $display("FAIL single_reeligible: got %0b want 1", eip); end
    endtask

    task automatic test_priority();
        logic [IDW-1:0] exp_ids [4];
        logic [NSRC-1:0] exp_ack [4];
        exp_ids = '{4'd2, 4'd3, 4'd5, 4'd0};
        exp_ack = '{8'h02, 8'h04, 8'h10, 8'h00};
        do_reset();
        set_prio(1, 5'd5); set_prio(2, 5'd5); set_prio(4, 5'd2);
        thres = 5'd0; ip = 8'b0001_0110;
        tick();
        for (int k = 0; k < 4; k++) begin
            claim_rd = 1'b1;
            tick();
            claim_rd = 1'b0;
            n_checks++; if (claim_data !== exp_ids[k]) begin n_fail++; $display("FAIL prio_claim%0d: got %0d want %0d", k, claim_data, exp_ids[k]); end
            n_checks++; if (ack !== exp_ack[k]) begin n_fail++; $display("FAIL prio_ack%0d: got %h want %h", k, ack, exp_ack[k]); end
            tick();
        end
        n_checks++; if (in_service !== 8'h16) begin n_fail++; $display("FAIL prio_in_service: got %h want 16", in_service); end
    endtask

    task automatic test_back_to_back();
        do_reset();
        set_prio(1, 5'd5); set_prio(2, 5'd5);
        ip = 8'b0000_0110;
        tick();
        claim_rd = 1'b1;
        tick();
        n_checks++; if (claim_data !== 4'd2) begin n_fail++; $display("FAIL b2b_first: got %0d want 2", claim_data); end
        tick();
        claim_rd = 1'b0;
        n_checks++; if (claim_data !== 4'd0) begin n_fail++; $display("FAIL b2b_second: got %0d want 0", claim_data); end
        n_checks++; if (ack !== 8'h00) begin n_fail++; $display("FAIL b2b_ack: got %h want 00", ack); end
        n_checks++; if (in_service !== 8'h02) begin n_fail++; $display("FAIL b2b_in_service: got %h want 02", in_service); end
    endtask

    task automatic test_threshold();
        do_reset();
        set_prio(0, 5'd4); thres = 5'd4; ip = 8'h01;
        tick();
        n_checks++; if (eip !== 1'b0) begin n_fail++; $display("FAIL thres_equal_eip: got %0b want 0", eip); end
        claim_rd = 1'b1;
        tick();
        claim_rd = 1'b0;
        n_checks++; if (claim_data !== 4'd0) begin n_fail++; $display("FAIL thres_claim: got %0d want 0", claim_data); end
        n_checks++; if (ack !== 8'h00) begin n_fail++; $display("FAIL thres_ack: got %h want 00", ack); end
        thres = 5'd3;
        tick();
        n_checks++; if (eip !== 1'b1) begin n_fail++; $display("FAIL thres_lowered_eip: got %0b want 1", eip); end
    endtask

    task automatic test_masking();
        do_reset();
        set_prio(0, 5'd7); set_prio(3, 5'd2); ip = 8'b0000_1001;
        tick();
        claim_rd = 1'b1;
        tick();
        claim_rd = 1'b0;
        n_checks++; if (claim_data !== 4'd1) begin n_fail++; $display("FAIL mask_claim1: got %0d want 1", claim_data); end
        tick();
        claim_rd = 1'b1;
        tick();
        claim_rd = 1'b0;
        n_checks++; if (claim_data !== 4'd4) begin n_fail++; $display("FAIL mask_claim4: got %0d want 4", claim_data); end
        n_checks++; if (in_service !== 8'h09) begin n_fail++; $display("FAIL mask_in_service: got %h want 09", in_service); end
        complete_wr = 1'b1; complete_id = 4'd1;
        tick();
        complete_wr = 1'b0;
        n_checks++; if (in_service !== 8'h08) begin n_fail++; $display("FAIL mask_complete1: got %h want 08", in_service); end
        tick();
        claim_rd = 1'b1;
        tick();
        claim_rd = 1'b0;
        n_checks++; if (claim_data !== 4'd1) begin n_fail++; $display("FAIL mask_reclaim1: got %0d want 1", claim_data); end
    endtask

    task automatic test_bad_complete();
        logic [IDW-1:0] bad_ids [3];
        bad_ids = '{4'd0, 4'd9, 4'd2};
        for (int k = 0; k < 3; k++) begin
            complete_wr = 1'b1; complete_id = bad_ids[k];
            tick();
            complete_wr = 1'b0;
            n_checks++; if (in_service !== 8'h09) begin n_fail++; $display("FAIL bad_complete_id%0d: got %h want 09", bad_ids[k], in_service); end
        end
    endtask

    task automatic test_simultaneous();
        set_prio(5, 5'd6); ip = 8'b0010_1001;
        tick();
        claim_rd = 1'b1; complete_wr = 1'b1; complete_id = 4'd4;
        tick();
        claim_rd = 1'b0; complete_wr = 1'b0;
        n_checks++; if (claim_data !== 4'd6) begin n_fail++; $display("FAIL simul_claim: got %0d want 6", claim_data); end
        n_checks++; if (ack !== 8'h20) begin n_fail++; $display("FAIL simul_ack: got %h want 20", ack); end
        n_checks++; if (in_service !== 8'h21) begin n_fail++; $display("FAIL simul_in_service: got %h want 21", in_service); end
    endtask

    task automatic test_async_reset();
        do_reset();
        set_prio(0, 5'd1); ip = 8'h01;
        tick();
        claim_rd = 1'b1;
        tick();
        claim_rd = 1'b0;
        n_checks++; if (ack !== 8'h01) begin n_fail++; $display("FAIL async_pre_ack: got %h want 01", ack); end
        rst = 1'b1;
        #1;
        n_checks++; if (ack !== 8'h00) begin n_fail++; $display("FAIL async_ack: got %h want 00", ack); end
        n_checks++; if (in_service !== 8'h00) begin n_fail++; $display("FAIL async_in_service: got %h want 00", in_service); end
        n_checks++; if (claim_data !== 4'd0) begin n_fail++; $display("FAIL async_claim_data: got %0d want 0", claim_data); end
        rst = 1'b0;
    endtask

    initial begin
        test_reset();
        test_single();
        test_priority();
        test_back_to_back();
        test_threshold();
        test_masking();
        test_bad_complete();
        test_simultaneous();
        test_async_reset();
        tick();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
